// File: rtl/plab4_net_router_pkg.sv
// Shared definitions for the timing-partitioned ring router.
package plab4_net_router_pkg;

    localparam int c_num_ports = 3;

    localparam logic [1:0] c_port_prev = 2'd0;
    localparam logic [1:0] c_port_term = 2'd1;
    localparam logic [1:0] c_port_next = 2'd2;

    localparam logic [c_num_ports-1:0] c_rst_ptr = 3'b001;

    // Binary index of a one-hot port vector; all-zero maps to port 0.
    function automatic logic [1:0] onehot_to_idx(input logic [c_num_ports-1:0] onehot);
        logic [1:0] idx;
        idx = c_port_prev;
        if (onehot[c_port_next]) begin
            idx = c_port_next;
        end else if (onehot[c_port_term]) begin
            idx = c_port_term;
        end
        return idx;
    endfunction

endpackage

// File: rtl/plab4_net_rr_arb3_core.sv
// Combinational 3-way round-robin picker: first request at or above the
// one-hot priority pointer, wrapping 2->0.
module plab4_net_rr_arb3_core
    import plab4_net_router_pkg::*;
(
    input  logic [c_num_ports-1:0] reqs,
    input  logic [c_num_ports-1:0] ptr,
    output logic [c_num_ports-1:0] winner,
    output logic [1:0]             idx
);

    always_comb begin
        winner = 3'b000;
        case (ptr)
            3'b010: begin
                if (reqs[1])      winner = 3'b010;
                else if (reqs[2]) winner = 3'b100;
                else if (reqs[0]) winner = 3'b001;
            end
            3'b100: begin
                if (reqs[2])      winner = 3'b100;
                else if (reqs[0]) winner = 3'b001;
                else if (reqs[1]) winner = 3'b010;
            end
            default: begin
                if (reqs[0])      winner = 3'b001;
                else if (reqs[1]) winner = 3'b010;
                else if (reqs[2]) winner = 3'b100;
            end
        endcase
    end

    assign idx = onehot_to_idx(winner);

endmodule

// File: rtl/plab4_net_router_output_ctrl_tp.sv
// Output-port control: round-robin arbitration with an independent priority
// pointer per security domain, so one domain cannot perturb the other's order.
module plab4_net_router_output_ctrl_tp
    import plab4_net_router_pkg::*;
#(
    parameter int                       p_num_inputs = c_num_ports,
    parameter logic [c_num_ports-1:0]   p_rst_ptr    = c_rst_ptr
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [p_num_inputs-1:0] reqs,
    output logic [p_num_inputs-1:0] grants,
    output logic [1:0]              sel,
    output logic                    out_val,
    input  logic                    out_rdy,
    input  logic                    domain
);

    logic [c_num_ports-1:0] r_ptr0;
    logic [c_num_ports-1:0] r_ptr1;
    logic [c_num_ports-1:0] w_ptr;
    logic [c_num_ports-1:0] w_winner;
    logic [c_num_ports-1:0] w_next_ptr;
    logic [1:0]             w_idx;
    logic                   w_fire;

    assign w_ptr = domain ? r_ptr1 : r_ptr0;

    plab4_net_rr_arb3_core u_arb (
        .reqs   (reqs),
        .ptr    (w_ptr),
        .winner (w_winner),
        .idx    (w_idx)
    );

    // Handshake: out_val is raised whenever any input requests and never
    // waits on out_rdy; a transfer (fire) happens on a rising edge where
    // out_val && out_rdy. Grants are only issued in the cycle that fires.
    assign out_val = |reqs;
    assign sel     = w_idx;
    assign grants  = w_winner & {c_num_ports{out_rdy}};
    assign w_fire  = out_val & out_rdy;

    // Priority moves one past the winner: rotate the one-hot winner left.
    assign w_next_ptr = {w_winner[1], w_winner[0], w_winner[2]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr0 <= p_rst_ptr;
            r_ptr1 <= p_rst_ptr;
        end else if (w_fire) begin
            if (domain) begin
                r_ptr1 <= w_next_ptr;
            end else begin
                r_ptr0 <= w_next_ptr;
            end
        end
    end

endmodule

// File: tb/tb_plab4_net_router_output_ctrl_tp.sv
// Directed, table-driven bench for the per-domain round-robin output control.
module tb_plab4_net_router_output_ctrl_tp;

    typedef struct {
        logic [2:0] reqs;
        logic       rdy;
        logic       dom;
        logic [2:0] exp_grants;
        logic [1:0] exp_sel;
        logic       exp_val;
    } vec_t;

    localparam int n_vec = 20;

    logic       clk;
    logic       reset;
    logic [2:0] reqs;
    logic [2:0] grants;
    logic [1:0] sel;
    logic       out_val;
    logic       out_rdy;
    logic       domain;

    int n_checks;
    int n_fails;

    vec_t vecs [n_vec];

    plab4_net_router_output_ctrl_tp dut (
        .clk     (clk),
        .reset   (reset),
        .reqs    (reqs),
        .grants  (grants),
        .sel     (sel),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .domain  (domain)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver
    task automatic drive(input logic [2:0] r, input logic rdy, input logic dom);
        reqs    = r;
        out_rdy = rdy;
        domain  = dom;
    endtask

    // Checker
    task automatic check_outs(input string name, input logic [2:0] eg,
                              input logic [1:0] es, input logic ev);
        n_checks += 3;
        if (grants !== eg) begin
            n_fails++;
            $display("FAIL %s grants: got %b expected %b", name, grants, eg);
        end
        if (sel !== es) begin
            n_fails++;
            $display("FAIL %s sel: got %0d expected %0d", name, sel, es);
        end
        if (out_val !== ev) begin
            n_fails++;
            $display("FAIL %s out_val: got %b expected %b", name, out_val, ev);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;

        //           reqs    rdy  dom   grants  sel   val
        vecs[0]  = '{3'b111, 1'b1, 1'b0, 3'b001, 2'd0, 1'b1};
        vecs[1]  = '{3'b111, 1'b1, 1'b0, 3'b010, 2'd1, 1'b1};
        vecs[2]  = '{3'b111, 1'b1, 1'b0, 3'b100, 2'd2, 1'b1};
        vecs[3]  = '{3'b111, 1'b1, 1'b0, 3'b001, 2'd0, 1'b1};
        vecs[4]  = '{3'b001, 1'b1, 1'b0, 3'b001, 2'd0, 1'b1};
        vecs[5]  = '{3'b111, 1'b1, 1'b1, 3'b001, 2'd0, 1'b1};
        vecs[6]  = '{3'b111, 1'b1, 1'b1, 3'b010, 2'd1, 1'b1};
        vecs[7]  = '{3'b111, 1'b1, 1'b0, 3'b010, 2'd1, 1'b1};
        vecs[8]  = '{3'b111, 1'b1, 1'b0, 3'b100, 2'd2, 1'b1};
        vecs[9]  = '{3'b101, 1'b0, 1'b0, 3'b000, 2'd0, 1'b1};
        vecs[10] = '{3'b101, 1'b0, 1'b0, 3'b000, 2'd0, 1'b1};
        vecs[11] = '{3'b101, 1'b0, 1'b0, 3'b000, 2'd0, 1'b1};
        vecs[12] = '{3'b101, 1'b1, 1'b0, 3'b001, 2'd0, 1'b1};
        vecs[13] = '{3'b101, 1'b1, 1'b0, 3'b100, 2'd2, 1'b1};
        vecs[14] = '{3'b010, 1'b1, 1'b0, 3'b010, 2'd1, 1'b1};
        vecs[15] = '{3'b010, 1'b1, 1'b0, 3'b010, 2'd1, 1'b1};
        vecs[16] = '{3'b111, 1'b1, 1'b0, 3'b100, 2'd2, 1'b1};
        vecs[17] = '{3'b010, 1'b1, 1'b0, 3'b010, 2'd1, 1'b1};
        vecs[18] = '{3'b111, 1'b1, 1'b0, 3'b100, 2'd2, 1'b1};
        vecs[19] = '{3'b111, 1'b1, 1'b0, 3'b001, 2'd0, 1'b1};

        // Reset state
        reset = 1'b0;
        drive(3'b000, 1'b1, 1'b0);
        #2;
        check_outs("reset_idle", 3'b000, 2'd0, 1'b0);
        drive(3'b111, 1'b1, 1'b0);
        #1;
        check_outs("reset_req", 3'b001, 2'd0, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Table vectors: checked before the edge that may fire
        for (int i = 0; i < n_vec; i++) begin
            drive(vecs[i].reqs, vecs[i].rdy, vecs[i].dom);
            @(negedge clk);
            check_outs($sformatf("vec%0d", i), vecs[i].exp_grants,
                       vecs[i].exp_sel, vecs[i].exp_val);
            @(posedge clk);
            #1;
        end

        // Mid-cycle reset: ptr0 is 010 here, ptr1 is 100
        drive(3'b111, 1'b1, 1'b0);
        #1;
        check_outs("pre_reset", 3'b010, 2'd1, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_outs("async_reset", 3'b001, 2'd0, 1'b1);
        @(posedge clk);
        #1;
        check_outs("fire_discarded", 3'b001, 2'd0, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check_outs("post_release", 3'b001, 2'd0, 1'b1);
        @(posedge clk);
        #1;
        check_outs("first_edge", 3'b010, 2'd1, 1'b1);
        drive(3'b111, 1'b1, 1'b1);
        #1;
        check_outs("ptr1_reset", 3'b001, 2'd0, 1'b1);

        // Idle across domain toggles leaves both pointers at reset value
        reset = 1'b0;
        #1;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(3'b000, 1'b1, k[0]);
            @(negedge clk);
            check_outs($sformatf("idle%0d", k), 3'b000, 2'd0, 1'b0);
            @(posedge clk);
            #1;
        end
        drive(3'b111, 1'b0, 1'b0);
        #1;
        check_outs("idle_ptr0", 3'b000, 2'd0, 1'b1);
        drive(3'b110, 1'b1, 1'b0);
        #1;
        check_outs("idle_ptr0_wrap", 3'b010, 2'd1, 1'b1);
        drive(3'b110, 1'b1, 1'b1);
        #1;
        check_outs("idle_ptr1_wrap", 3'b010, 2'd1, 1'b1);
        drive(3'b111, 1'b1, 1'b1);
        #1;
        check_outs("idle_ptr1", 3'b001, 2'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
